product_accumulator: RTL and testbench

- Downstream stage of the n-bit unsigned multiplier: consumes its 2n-bit product Z and accumulates a fixed-length group of products, giving a dot-product / multiply-accumulate result.
- Valid/ready handshake on both sides, so the block can sit behind either the combinational multiplier or a multi-cycle one.
- One result is emitted per group of LEN products, or earlier when a product is tagged last.

---
 rtl/product_accumulator.sv | 101 ++++++++++
 tb/tb_product_accumulator.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/product_accumulator.sv
// Multiply-accumulate back end: sums groups of up to LEN unsigned products from the
// upstream n-bit multiplier and hands each group result downstream over valid/ready.
module product_accumulator #(
  parameter int unsigned n     = 16,
  parameter int unsigned GUARD = 4,
  parameter int unsigned LEN   = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [2*n-1:0]               prod,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [2*n+GUARD-1:0]         sum,
  output logic [$clog2(LEN+1)-1:0]     count,
  output logic                         overflow
);

  localparam int unsigned AW = 2 * n + GUARD;
  localparam int unsigned CW = $clog2(LEN + 1);

  typedef enum logic {StAccum, StHold} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ovf_q, ovf_d;
  logic            close;
  logic [AW:0]     total;

  // Extra top bit of the running total captures the carry out of the accumulator.
  assign total = {1'b0, acc_q} + {{(GUARD + 1){1'b0}}, prod};

  // Handshake outputs are a pure function of the state.
  always_comb begin
    in_ready  = (state_q == StAccum);
    out_valid = (state_q == StHold);
  end

  // Next-state: accumulate while in StAccum, wait for the consumer in StHold.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    close   = 1'b0;
    unique case (state_q)
      StAccum: begin
        if (in_valid) begin
          acc_d = total[AW-1:0];
          cnt_d = cnt_q + CW'(1);
          ovf_d = ovf_q | total[AW];
          if ((cnt_q == CW'(LEN - 1)) || in_last) begin
            close   = 1'b1;
            state_d = StHold;
          end
        end
      end
      StHold: begin
        if (out_ready) begin
          state_d = StAccum;
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = StAccum;
    endcase
  end

  // State and accumulator registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StAccum;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // Result registers load only on the edge that closes a group, so they stay stable in StHold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum      <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (close) begin
      sum      <= acc_d;
      count    <= cnt_d;
      overflow <= ovf_d;
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Randomized and directed checks of product_accumulator against a group-level model.
// Two instances share stimulus: GUARD=4 (never overflows) and GUARD=1 (overflows on full scale).
module tb_product_accumulator;

  localparam int unsigned LEN = 4;
  localparam int unsigned AWA = 36;
  localparam int unsigned AWB = 33;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] prod;
  logic        in_last;
  logic        out_ready;

  logic        a_in_ready, a_out_valid, a_overflow;
  logic [35:0] a_sum;
  logic [2:0]  a_count;
  logic        b_in_ready, b_out_valid, b_overflow;
  logic [32:0] b_sum;
  logic [2:0]  b_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: products of the open group, and the last emitted group result.
  longint unsigned m_prods[$];
  bit              m_hold;
  bit              m_acc;
  longint unsigned e_total;
  int unsigned     e_count;

  product_accumulator #(.n(16), .GUARD(4), .LEN(LEN)) u_dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready), .prod(prod),
    .in_last(in_last), .out_valid(a_out_valid), .out_ready(out_ready), .sum(a_sum),
    .count(a_count), .overflow(a_overflow)
  );

  product_accumulator #(.n(16), .GUARD(1), .LEN(LEN)) u_dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready), .prod(prod),
    .in_last(in_last), .out_valid(b_out_valid), .out_ready(out_ready), .sum(b_sum),
    .count(b_count), .overflow(b_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic longint unsigned mask(input longint unsigned v, input int unsigned w);
    return v & ((64'd1 << w) - 64'd1);
  endfunction

  task automatic model_reset();
    m_prods.delete();
    m_hold  = 1'b0;
    m_acc   = 1'b0;
    e_total = 0;
    e_count = 0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".a_in_ready"},  a_in_ready,  !m_hold);
    check({tag, ".a_out_valid"}, a_out_valid, m_hold);
    check({tag, ".a_sum"},       a_sum,       mask(e_total, AWA));
    check({tag, ".a_count"},     a_count,     e_count);
    check({tag, ".a_overflow"},  a_overflow,  (e_total >> AWA) != 0);
    check({tag, ".b_in_ready"},  b_in_ready,  !m_hold);
    check({tag, ".b_out_valid"}, b_out_valid, m_hold);
    check({tag, ".b_sum"},       b_sum,       mask(e_total, AWB));
    check({tag, ".b_count"},     b_count,     e_count);
    check({tag, ".b_overflow"},  b_overflow,  (e_total >> AWB) != 0);
  endtask

  // One clock: update the model from the inputs seen at the edge, then check on the falling edge.
  task automatic tick();
    @(posedge clk);
    m_acc = 1'b0;
    if (m_hold) begin
      if (out_ready) m_hold = 1'b0;
    end else if (in_valid) begin
      m_acc = 1'b1;
      m_prods.push_back(longint'(prod));
      if (m_prods.size() == LEN || in_last) begin
        e_total = 0;
        foreach (m_prods[i]) e_total += m_prods[i];
        e_count = m_prods.size();
        m_prods.delete();
        m_hold = 1'b1;
      end
    end
    @(negedge clk);
    check_all("cyc");
  endtask

  // Present a product and clock until it is taken; returns the number of cycles spent.
  task automatic push(input logic [31:0] p, input logic last, output int cycles);
    in_valid = 1'b1;
    prod     = p;
    in_last  = last;
    cycles   = 0;
    do begin
      tick();
      cycles++;
    end while (!m_acc && cycles < 20);
    if (!m_acc) check("push_timeout", 0, 1);
  endtask

  task automatic idle(input int k);
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (k) tick();
  endtask

  task automatic async_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_all("arst");
    check("arst_sum_zero", a_sum, 0);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int c;
    rst = 1'b1;
    in_valid = 1'b0;
    prod = '0;
    in_last = 1'b0;
    out_ready = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    rst = 1'b0;

    // 1: four back-to-back products
    push(32'd4500, 1'b0, c);
    push(32'd880, 1'b0, c);
    push(32'd640, 1'b0, c);
    push(32'd1024, 1'b0, c);
    check("t1_valid", a_out_valid, 1);
    check("t1_ready", a_in_ready, 0);
    check("t1_sum", a_sum, 7044);
    check("t1_count", a_count, 4);
    check("t1_ovf", a_overflow, 0);
    idle(1);
    check("t1_valid_drop", a_out_valid, 0);
    check("t1_ready_back", a_in_ready, 1);

    // 2: early close, then a fresh group
    push(32'd1200, 1'b1, c);
    check("t2_sum", a_sum, 1200);
    check("t2_count", a_count, 1);
    idle(1);
    push(32'd5, 1'b0, c);
    push(32'd7, 1'b0, c);
    push(32'd9, 1'b0, c);
    push(32'd11, 1'b0, c);
    check("t2_sum2", a_sum, 32);
    check("t2_count2", a_count, 4);
    idle(1);

    // 3: backpressure with a pending product
    out_ready = 1'b0;
    push(32'd1, 1'b0, c);
    push(32'd2, 1'b0, c);
    push(32'd3, 1'b0, c);
    push(32'd4, 1'b0, c);
    in_valid = 1'b1;
    prod = 32'd3;
    in_last = 1'b1;
    repeat (5) tick();
    check("t3_hold_sum", a_sum, 10);
    check("t3_hold_valid", a_out_valid, 1);
    check("t3_hold_ready", a_in_ready, 0);
    out_ready = 1'b1;
    tick();
    check("t3_release", a_in_ready, 1);
    tick();
    check("t3_taken_valid", a_out_valid, 1);
    check("t3_taken_sum", a_sum, 3);
    check("t3_taken_count", a_count, 1);
    idle(1);

    // 4: gaps inside a group
    push(32'd4500, 1'b0, c);
    idle(3);
    push(32'd880, 1'b0, c);
    idle(1);
    push(32'd640, 1'b0, c);
    push(32'd1024, 1'b0, c);
    check("t4_sum", a_sum, 7044);
    check("t4_count", a_count, 4);
    idle(1);

    // 5: full-scale group overflows the narrow instance only
    repeat (4) push(32'hFFFF_FFFF, 1'b0, c);
    check("t5_b_ovf", b_overflow, 1);
    check("t5_b_sum", b_sum, 64'h1_FFFF_FFFC);
    check("t5_a_ovf", a_overflow, 0);
    check("t5_a_sum", a_sum, 64'h3_FFFF_FFFC);
    idle(1);
    push(32'd1, 1'b0, c);
    push(32'd2, 1'b0, c);
    push(32'd3, 1'b0, c);
    push(32'd4, 1'b0, c);
    check("t5_b_ovf_clear", b_overflow, 0);
    check("t5_b_sum_small", b_sum, 10);
    idle(1);

    // 6: async reset mid-group and in hold
    push(32'd10, 1'b0, c);
    push(32'd20, 1'b0, c);
    in_valid = 1'b0;
    async_reset();
    out_ready = 1'b0;
    push(32'd1, 1'b0, c);
    push(32'd2, 1'b0, c);
    push(32'd3, 1'b0, c);
    push(32'd4, 1'b0, c);
    in_valid = 1'b0;
    async_reset();
    check("t6_no_valid", a_out_valid, 0);
    out_ready = 1'b1;
    idle(2);
    push(32'd4500, 1'b1, c);
    check("t6_sum", a_sum, 4500);
    check("t6_count", a_count, 1);
    idle(1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(59) == 0) begin
        async_reset();
      end else begin
        in_valid  = ($urandom_range(2) != 0);
        prod      = ($urandom_range(3) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(3)) : $urandom;
        in_last   = ($urandom_range(4) == 0);
        out_ready = ($urandom_range(3) != 0);
        tick();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
